// File: rtl/wbu.sv
// Write-back stage: integer register file with same-cycle write bypass,
// commit trace, retire counter and the ebreak halt state machine.
module wbu #(
    parameter int XLEN  = 64,
    parameter int NREG  = 32,
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [4:0]       mmu_index_rd,
    input  logic             mmu_wb_en,
    input  logic [XLEN-1:0]  mmu_wb_data,
    input  logic             mmu_valid,
    input  logic             mmu_ebreak_en,
    input  logic [XLEN-1:0]  mmu_pc,
    input  logic [31:0]      mmu_instr,
    input  logic [4:0]       rs1_index,
    input  logic [4:0]       rs2_index,
    output logic [XLEN-1:0]  rs1_data,
    output logic [XLEN-1:0]  rs2_data,
    output logic             wbu_valid,
    output logic [XLEN-1:0]  wbu_pc,
    output logic [31:0]      wbu_instr,
    output logic [CNT_W-1:0] retire_cnt,
    output logic             halt,
    output logic [XLEN-1:0]  halt_code
);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    localparam logic [4:0] A0_IDX = 5'd10;

    state_t          state;
    state_t          state_nxt;
    logic            halt_go;
    logic            retire;
    logic            wr_en;
    logic            byp_en;
    logic [XLEN-1:0] x10_val;
    logic [XLEN-1:0] regs [NREG];

    // An instruction retires only while running; once halted every slot is dropped.
    assign retire = mmu_valid & (state == RUN);
    assign byp_en = retire & mmu_wb_en;
    assign wr_en  = byp_en & (mmu_index_rd != 5'd0);

    // Read ports: x0 is hard-wired to zero, a retiring write to the same
    // index is forwarded so decode sees it without waiting for the edge.
    assign rs1_data = (rs1_index == 5'd0) ? '0 :
                      (byp_en && mmu_index_rd == rs1_index) ? mmu_wb_data :
                      regs[rs1_index];
    assign rs2_data = (rs2_index == 5'd0) ? '0 :
                      (byp_en && mmu_index_rd == rs2_index) ? mmu_wb_data :
                      regs[rs2_index];

    // a0 as decode would see it this cycle; captured as the exit code on ebreak.
    assign x10_val = (byp_en && mmu_index_rd == A0_IDX) ? mmu_wb_data : regs[A0_IDX];

    assign halt = (state == HALT);

    // Register file write; the whole file clears on reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[mmu_index_rd] <= mmu_wb_data;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state: a valid ebreak moves RUN to HALT, HALT is terminal.
    always_comb begin
        state_nxt = state;
        halt_go   = 1'b0;
        case (state)
            RUN: begin
                if (mmu_valid && mmu_ebreak_en) begin
                    state_nxt = HALT;
                    halt_go   = 1'b1;
                end
            end
            HALT: begin
                state_nxt = HALT;
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    // Exit code capture on the halting edge, frozen afterwards.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            halt_code <= '0;
        end else if (halt_go) begin
            halt_code <= x10_val;
        end
    end

    // Commit trace: one pulse per retired instruction, pc/instr held between commits.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wbu_valid <= 1'b0;
            wbu_pc    <= '0;
            wbu_instr <= '0;
        end else begin
            wbu_valid <= retire;
            if (retire) begin
                wbu_pc    <= mmu_pc;
                wbu_instr <= mmu_instr;
            end
        end
    end

    // Retire counter, wrapping silently at 2^CNT_W.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            retire_cnt <= '0;
        end else if (retire) begin
            retire_cnt <= retire_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_wbu.sv
// Bench for wbu: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a behavioural model.
module tb_wbu;

    logic        clk  = 1'b0;
    logic        rstn = 1'b0;
    logic [4:0]  mmu_index_rd  = '0;
    logic        mmu_wb_en     = 1'b0;
    logic [63:0] mmu_wb_data   = '0;
    logic        mmu_valid     = 1'b0;
    logic        mmu_ebreak_en = 1'b0;
    logic [63:0] mmu_pc        = '0;
    logic [31:0] mmu_instr     = '0;
    logic [4:0]  rs1_index     = '0;
    logic [4:0]  rs2_index     = '0;

    logic [63:0] rs1_data, rs2_data, wbu_pc, halt_code, retire_cnt;
    logic        wbu_valid, halt;
    logic [31:0] wbu_instr;

    logic [63:0] w_rs1_data, w_rs2_data, w_wbu_pc, w_halt_code;
    logic [3:0]  w_retire_cnt;
    logic        w_wbu_valid, w_halt;
    logic [31:0] w_wbu_instr;

    int n_total = 0;
    int n_pass  = 0;
    bit cmp_en  = 1'b0;

    always #5 clk = ~clk;

    wbu dut (
        .clk(clk), .rstn(rstn),
        .mmu_index_rd(mmu_index_rd), .mmu_wb_en(mmu_wb_en), .mmu_wb_data(mmu_wb_data),
        .mmu_valid(mmu_valid), .mmu_ebreak_en(mmu_ebreak_en), .mmu_pc(mmu_pc),
        .mmu_instr(mmu_instr), .rs1_index(rs1_index), .rs2_index(rs2_index),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .wbu_valid(wbu_valid),
        .wbu_pc(wbu_pc), .wbu_instr(wbu_instr), .retire_cnt(retire_cnt),
        .halt(halt), .halt_code(halt_code)
    );

    wbu #(.CNT_W(4)) dut_w (
        .clk(clk), .rstn(rstn),
        .mmu_index_rd(mmu_index_rd), .mmu_wb_en(mmu_wb_en), .mmu_wb_data(mmu_wb_data),
        .mmu_valid(mmu_valid), .mmu_ebreak_en(mmu_ebreak_en), .mmu_pc(mmu_pc),
        .mmu_instr(mmu_instr), .rs1_index(rs1_index), .rs2_index(rs2_index),
        .rs1_data(w_rs1_data), .rs2_data(w_rs2_data), .wbu_valid(w_wbu_valid),
        .wbu_pc(w_wbu_pc), .wbu_instr(w_wbu_instr), .retire_cnt(w_retire_cnt),
        .halt(w_halt), .halt_code(w_halt_code)
    );

    // Behavioural model state
    logic [63:0] m_regs [32];
    bit          m_halt;
    logic [63:0] m_hc, m_pc, m_cnt;
    logic [31:0] m_instr;
    bit          m_valid;

    function automatic logic [63:0] exp_read(input logic [4:0] idx);
        if (idx == 5'd0) return 64'd0;
        if (!m_halt && mmu_valid && mmu_wb_en && mmu_index_rd == idx) return mmu_wb_data;
        return m_regs[idx];
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 64'd0;
            m_halt = 0; m_hc = 0; m_pc = 0; m_cnt = 0; m_instr = 0; m_valid = 0;
        end else begin
            logic        ret;
            logic [63:0] a0;
            ret = mmu_valid && !m_halt;
            a0  = exp_read(5'd10);
            if (ret) begin
                if (mmu_ebreak_en) begin
                    m_halt = 1;
                    m_hc   = a0;
                end
                if (mmu_wb_en && mmu_index_rd != 5'd0) m_regs[mmu_index_rd] = mmu_wb_data;
                m_cnt   = m_cnt + 64'd1;
                m_pc    = mmu_pc;
                m_instr = mmu_instr;
            end
            m_valid = ret;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m_rs1", rs1_data, exp_read(rs1_index));
            chk("m_rs2", rs2_data, exp_read(rs2_index));
            chk("m_valid", {63'd0, wbu_valid}, {63'd0, m_valid});
            chk("m_pc", wbu_pc, m_pc);
            chk("m_instr", {32'd0, wbu_instr}, {32'd0, m_instr});
            chk("m_cnt", retire_cnt, m_cnt);
            chk("m_cnt4", {60'd0, w_retire_cnt}, {60'd0, m_cnt[3:0]});
            chk("m_halt", {63'd0, halt}, {63'd0, m_halt});
            chk("m_hcode", halt_code, m_hc);
        end
    end

    task automatic drive(input bit v, input bit we, input logic [4:0] rd, input logic [63:0] d,
                         input bit eb, input logic [63:0] pc, input logic [31:0] ins);
        mmu_valid = v; mmu_wb_en = we; mmu_index_rd = rd; mmu_wb_data = d;
        mmu_ebreak_en = eb; mmu_pc = pc; mmu_instr = ins;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        step(); step();
        cmp_en = 1'b1;
        // Reset state while rstn is held low
        chk("rst_cnt", retire_cnt, 64'd0);
        chk("rst_halt", {63'd0, halt}, 64'd0);
        chk("rst_valid", {63'd0, wbu_valid}, 64'd0);
        rstn = 1'b1;

        // Write x5 with same-cycle bypass
        drive(1, 1, 5'd5, 64'hDEAD_BEEF_0000_0001, 0, 64'h8000_0000, 32'h0000_0013);
        rs1_index = 5'd5; rs2_index = 5'd6;
        #1;
        chk("byp_rs1", rs1_data, 64'hDEAD_BEEF_0000_0001);
        chk("byp_rs2", rs2_data, 64'd0);
        step();
        drive(0, 0, 5'd0, 64'd0, 0, 64'd0, 32'd0);
        #1;
        chk("reg_rs1", rs1_data, 64'hDEAD_BEEF_0000_0001);
        chk("wr_valid", {63'd0, wbu_valid}, 64'd1);

        // x0 write and invalid-slot write
        drive(1, 1, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 64'h8000_0004, 32'h0000_0013);
        rs1_index = 5'd0;
        #1;
        chk("x0_rs1", rs1_data, 64'd0);
        step();
        drive(0, 1, 5'd7, 64'h5555_5555_5555_5555, 0, 64'h8000_0008, 32'h0000_0013);
        rs1_index = 5'd7;
        #1;
        chk("inv_byp", rs1_data, 64'd0);
        step();
        drive(0, 0, 5'd0, 64'd0, 0, 64'd0, 32'd0);
        #1;
        chk("inv_x7", rs1_data, 64'd0);
        chk("inv_valid", {63'd0, wbu_valid}, 64'd0);
        chk("inv_cnt", retire_cnt, 64'd2);

        // Asynchronous reset mid-run
        rs1_index = 5'd5; rs2_index = 5'd5;
        #1;
        chk("pre_rst_x5", rs1_data, 64'hDEAD_BEEF_0000_0001);
        rstn = 1'b0;
        #1;
        chk("arst_rs1", rs1_data, 64'd0);
        chk("arst_rs2", rs2_data, 64'd0);
        chk("arst_cnt", retire_cnt, 64'd0);
        chk("arst_halt", {63'd0, halt}, 64'd0);
        chk("arst_valid", {63'd0, wbu_valid}, 64'd0);
        step(); step();
        rstn = 1'b1;

        // Commit trace and counter: three slots then a bubble
        for (int i = 0; i < 4; i++) begin
            if (i < 3) drive(1, 0, 5'd0, 64'd0, 0, 64'h8000_0000 + 64'(4 * i), 32'h100 + 32'(i));
            else       drive(0, 0, 5'd0, 64'd0, 0, 64'h1234, 32'hBAD);
            step();
            chk("trc_valid", {63'd0, wbu_valid}, (i < 3) ? 64'd1 : 64'd0);
            chk("trc_pc", wbu_pc, (i < 3) ? 64'h8000_0000 + 64'(4 * i) : 64'h8000_0008);
        end
        chk("trc_cnt", retire_cnt, 64'd3);

        // Halt on ebreak, exit code from a0
        drive(1, 1, 5'd10, 64'h2A, 0, 64'h8000_000C, 32'h02A0_0513);
        step();
        drive(1, 0, 5'd0, 64'd0, 1, 64'h8000_0010, 32'h0010_0073);
        step();
        chk("hlt_halt", {63'd0, halt}, 64'd1);
        chk("hlt_code", halt_code, 64'h2A);
        chk("hlt_cnt", retire_cnt, 64'd5);
        chk("hlt_valid", {63'd0, wbu_valid}, 64'd1);
        drive(1, 1, 5'd10, 64'h99, 0, 64'h8000_0014, 32'h0990_0513);
        rs1_index = 5'd10;
        #1;
        chk("hlt_nobyp", rs1_data, 64'h2A);
        step();
        chk("hlt_x10", rs1_data, 64'h2A);
        chk("hlt_valid2", {63'd0, wbu_valid}, 64'd0);
        chk("hlt_cnt2", retire_cnt, 64'd5);
        chk("hlt_pc", wbu_pc, 64'h8000_0010);

        // Reset clears halt; then counter wrap on the 4-bit build
        drive(0, 0, 5'd0, 64'd0, 0, 64'd0, 32'd0);
        rstn = 1'b0;
        #1;
        chk("rst_unhalt", {63'd0, halt}, 64'd0);
        step();
        rstn = 1'b1;
        for (int i = 0; i < 17; i++) begin
            drive(1, 0, 5'd0, 64'd0, 0, 64'h8000_0000 + 64'(4 * i), 32'(i));
            step();
        end
        drive(0, 0, 5'd0, 64'd0, 0, 64'd0, 32'd0);
        #1;
        chk("wrap_cnt4", {60'd0, w_retire_cnt}, 64'd1);
        chk("wrap_cnt64", retire_cnt, 64'd17);

        // Randomized run with periodic resets
        for (int c = 0; c < 3000; c++) begin
            if (c % 400 == 399) begin
                rstn = 1'b0;
                step();
                rstn = 1'b1;
            end
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                  5'($urandom_range(0, 15)), {$urandom, $urandom},
                  $urandom_range(0, 99) == 0, {32'd0, $urandom}, $urandom);
            rs1_index = 5'($urandom_range(0, 15));
            rs2_index = ($urandom_range(0, 3) == 0) ? rs1_index : 5'($urandom_range(0, 31));
            step();
        end

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/wbu.md
Name: wbu

Overview:
- Write-back stage, directly downstream of the memory-access stage.
- Consumes that stage's registered result (rd index, write-enable, write data, valid, ebreak, pc, instr).
- Owns the 32-entry integer register file and serves the decode stage's two read ports, with same-cycle write bypass.
- Keeps the retire counter and the commit trace, and runs the ebreak halt state machine used by the simulation harness.

Parameters:
- XLEN, 64, data/pc width
- NREG, 32, number of architectural registers (index width fixed at 5)
- CNT_W, 64, retire counter width

Ports:
- clk  in  1  clock
- rstn  in  1  reset; asynchronous, active-low
- mmu_index_rd  in  5  destination register index
- mmu_wb_en  in  1  instruction writes rd
- mmu_wb_data  in  XLEN  write-back data
- mmu_valid  in  1  slot holds a real instruction
- mmu_ebreak_en  in  1  instruction is ebreak
- mmu_pc  in  XLEN  instruction pc
- mmu_instr  in  32  instruction word
- rs1_index  in  5  read port 1 index (decode)
- rs2_index  in  5  read port 2 index (decode)
- rs1_data  out  XLEN  read port 1 data
- rs2_data  out  XLEN  read port 2 data
- wbu_valid  out  1  commit pulse, one per retired instruction
- wbu_pc  out  XLEN  pc of committed instruction
- wbu_instr  out  32  instr of committed instruction
- retire_cnt  out  CNT_W  count of retired instructions
- halt  out  1  ebreak reached; sticky
- halt_code  out  XLEN  x10 (a0) captured at halt

Behaviour:
- Reset (rstn low, takes effect immediately, no clock needed):
  - all registers x0..x31 = 0
  - FSM = RUN
  - wbu_valid = 0, wbu_pc = 0, wbu_instr = 0, retire_cnt = 0, halt = 0, halt_code = 0
- Reset asserted mid-run clears everything, including HALT. The first edge after release behaves as RUN.
- retire = mmu_valid & (state == RUN).
- Register write: on posedge, if retire & mmu_wb_en & (mmu_index_rd != 0), then reg[mmu_index_rd] <= mmu_wb_data.
  - x0 is never written; it always reads 0.
  - mmu_wb_en with mmu_valid=0 is ignored.
- Read ports are combinational, zero latency. For each port p:
  - if index_p == 0: data = 0
  - else if retire & mmu_wb_en & (mmu_index_rd == index_p): data = mmu_wb_data (bypass)
  - else: data = reg[index_p]
  - Both ports may hit the bypass on the same index simultaneously.
- Commit trace: on posedge, wbu_valid <= retire, wbu_pc <= mmu_pc, wbu_instr <= mmu_instr.
  - wbu_pc and wbu_instr update only when retire=1 and hold otherwise.
  - Latency is 1 cycle from the input slot.
- Retire counter: on posedge, if retire, retire_cnt <= retire_cnt + 1, modulo 2^CNT_W (wraps to 0, no flag).
- FSM states:
  - RUN: if mmu_valid & mmu_ebreak_en, go to HALT at the next edge. On that same edge, halt <= 1 and halt_code <= current read value of x10. That read applies the bypass rule, so a same-slot write to x10 is visible, although ebreak does not normally write. The ebreak itself counts as retired: wbu_valid pulses, retire_cnt increments, and its rd write is honoured if mmu_wb_en=1.
  - HALT: terminal until reset. Inputs are ignored: no register writes, no counter increment, wbu_valid = 0, halt_code frozen. Read ports keep serving register contents with no bypass.
- mmu_ebreak_en with mmu_valid=0: no effect.
- All state updates are on posedge clk only, except reset.

Test Plan:
- Reset: rstn=0 mid-run after writes -> every read port returns 0, retire_cnt=0, halt=0, wbu_valid=0 immediately, before any clock edge.
- Write/read/bypass: valid write x5=0xDEAD_BEEF_0000_0001 -> in the same cycle, rs1_index=5 reads 0xDEAD_BEEF_0000_0001 (bypass). The next cycle it reads the same value from the register. rs2_index=6 reads 0.
- x0 and invalid slots: valid write rd=0, data=0xFFFF..FF -> rs1_index=0 reads 0. Write rd=7 with mmu_valid=0 -> x7 stays 0, no wbu_valid pulse, retire_cnt unchanged.
- Commit trace/counter: 3 consecutive valid slots (pc 0x80000000/4/8) then 1 bubble -> wbu_valid = 1,1,1,0 one cycle later, wbu_pc follows 0x80000000/4/8 then holds 0x80000008, retire_cnt = 3.
- Halt: x10=0x2A, then a valid ebreak at pc 0x80000010 -> next edge halt=1, halt_code=0x2A, retire_cnt +1. A subsequent valid write x10=0x99 is ignored: x10 reads 0x2A, wbu_valid stays 0.
- Wrap: CNT_W=4 build, 17 valid retires -> retire_cnt=1.
